load_data_align: RTL and testbench

//  Load-side counterpart of the store data shifter in the multi-cycle MIPS datapath.

---
 rtl/load_data_align.sv | 188 ++++++++++++++++++
 tb/tb_load_data_align.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/load_data_align.sv
// Load data aligner: issues a word-aligned read and formats LB/LBU/LH/LHU/LW/LWL/LWR results for Rt.
// Latency: start sampled -> REQ; the edge after mem_rdy raises done with load_data (minimum 2 cycles).
// Backpressure: mem_rd_req is held until mem_rdy; start is ignored while busy. Optional: LOAD_ALIGN_TIMEOUT_EN.
module load_data_align #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] rt_in,
    output logic        mem_rd_req,
    output logic [31:0] mem_addr,
    input  logic        mem_rdy,
    input  logic [31:0] mem_rdata,
    output logic [31:0] load_data,
    output logic        done,
    output logic        addr_err,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LWL = 6'b100010;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LWR = 6'b100110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rt_q, rt_d;
    logic [31:0] data_q, data_d;
    logic [31:0] aligned;
    logic        valid_op;
    logic        misaligned;

    // Decode the incoming request: is it a load, and does its width fit the address
    always_comb begin
        valid_op   = 1'b0;
        misaligned = 1'b0;
        case (op)
            OP_LB, OP_LBU, OP_LWL, OP_LWR: valid_op = 1'b1;
            OP_LH, OP_LHU: begin
                valid_op   = 1'b1;
                misaligned = addr[0];
            end
            OP_LW: begin
                valid_op   = 1'b1;
                misaligned = (addr[1:0] != 2'b00);
            end
            default: ;
        endcase
    end

    // Big-endian extraction and Rt merge of the returned word
    always_comb begin
        logic [1:0]  k;
        logic [4:0]  shl;
        logic [4:0]  shr;
        logic [31:0] shifted;
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        k       = addr_q[1:0];
        shl     = {k, 3'b000};          // 8*k
        shr     = {~k, 3'b000};         // 8*(3-k)
        shifted = mem_rdata >> shr;
        byte_v  = shifted[7:0];
        half_v  = k[1] ? mem_rdata[15:0] : mem_rdata[31:16];
        aligned = mem_rdata;
        case (op_q)
            OP_LB:  aligned = {{24{byte_v[7]}}, byte_v};
            OP_LBU: aligned = {24'h0, byte_v};
            OP_LH:  aligned = {{16{half_v[15]}}, half_v};
            OP_LHU: aligned = {16'h0, half_v};
            OP_LW:  aligned = mem_rdata;
            // k=0 gives an empty mask, so the whole word is taken
            OP_LWL: aligned = (mem_rdata << shl) | (rt_q & ((32'h1 << shl) - 32'h1));
            // k=3 gives a zero shift, so the whole word is taken
            OP_LWR: aligned = shifted | (rt_q & ~(32'hFFFF_FFFF >> shr));
            default: aligned = mem_rdata;
        endcase
    end

`ifdef LOAD_ALIGN_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tout_q, tout_d;
`endif

    // Next-state, request latching and result capture
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        rt_d    = rt_q;
        data_d  = data_q;
`ifdef LOAD_ALIGN_TIMEOUT_EN
        cnt_d   = cnt_q;
        tout_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef LOAD_ALIGN_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (start && valid_op) begin
                    op_d    = op;
                    addr_d  = addr;
                    rt_d    = rt_in;
                    state_d = misaligned ? ST_ERR : ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_rdy) begin
                    data_d  = aligned;
                    state_d = ST_DONE;
                end
`ifdef LOAD_ALIGN_TIMEOUT_EN
                // A ready in the terminal cycle still captures normally
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    tout_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            rt_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            rt_q    <= rt_d;
            data_q  <= data_d;
        end
    end

`ifdef LOAD_ALIGN_TIMEOUT_EN
    // Wait counter and registered timeout pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            tout_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tout_q <= tout_d;
        end
    end

    assign timeout_err = tout_q;
`else
    logic unused_cfg;
    assign unused_cfg  = |TIMEOUT_CYCLES;
    assign timeout_err = 1'b0;
`endif

    assign mem_rd_req = (state_q == ST_REQ);
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign load_data  = data_q;
    assign done       = (state_q == ST_DONE);
    assign addr_err   = (state_q == ST_ERR);
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_load_data_align.sv
module tb_load_data_align;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LWL = 6'b100010;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LWR = 6'b100110;
    localparam logic [5:0] OP_SW  = 6'b101011;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] rt_in;
    logic        mem_rd_req;
    logic [31:0] mem_addr;
    logic        mem_rdy;
    logic [31:0] mem_rdata;
    logic [31:0] load_data;
    logic        done;
    logic        addr_err;
    logic        busy;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;

    load_data_align #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .addr        (addr),
        .rt_in       (rt_in),
        .mem_rd_req  (mem_rd_req),
        .mem_addr    (mem_addr),
        .mem_rdy     (mem_rdy),
        .mem_rdata   (mem_rdata),
        .load_data   (load_data),
        .done        (done),
        .addr_err    (addr_err),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; afterwards the DUT has sampled it
    task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] r);
        start = 1'b1;
        op    = o;
        addr  = a;
        rt_in = r;
        tick();
        start = 1'b0;
        op    = 6'h00;
        addr  = 32'h0;
        rt_in = 32'h0;
    endtask

    // Full load: wait 'delay' cycles in REQ, then return 'd' and check the result
    task automatic do_load(input string tag, input logic [5:0] o, input logic [31:0] a,
                           input logic [31:0] r, input logic [31:0] d, input int delay,
                           input logic [31:0] exp, input bit pester);
        issue(o, a, r);
        check($sformatf("%s_req", tag), {31'b0, mem_rd_req}, 32'd1);
        check($sformatf("%s_maddr", tag), mem_addr, {a[31:2], 2'b00});
        for (int i = 0; i < delay; i++) begin
            if (pester) begin
                start = 1'b1;
                op    = OP_LW;
                addr  = 32'h0000_0100;
                rt_in = 32'h5555_5555;
            end
            tick();
            start = 1'b0;
            check($sformatf("%s_wreq%0d", tag, i), {31'b0, mem_rd_req}, 32'd1);
            check($sformatf("%s_waddr%0d", tag, i), mem_addr, {a[31:2], 2'b00});
            check($sformatf("%s_wdone%0d", tag, i), {31'b0, done}, 32'd0);
        end
        mem_rdy   = 1'b1;
        mem_rdata = d;
        tick();
        mem_rdy   = 1'b0;
        mem_rdata = 32'hDEAD_DEAD;
        check($sformatf("%s_done", tag), {31'b0, done}, 32'd1);
        check($sformatf("%s_data", tag), load_data, exp);
        check($sformatf("%s_reqoff", tag), {31'b0, mem_rd_req}, 32'd0);
        check($sformatf("%s_tout", tag), {31'b0, timeout_err}, 32'd0);
        tick();
        check($sformatf("%s_pulse", tag), {31'b0, done}, 32'd0);
        check($sformatf("%s_idle", tag), {31'b0, busy}, 32'd0);
        check($sformatf("%s_hold", tag), load_data, exp);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        op        = 6'h00;
        addr      = 32'h0;
        rt_in     = 32'h0;
        mem_rdy   = 1'b0;
        mem_rdata = 32'h0;
        #12;
        check("rst_req",  {31'b0, mem_rd_req}, 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_data", load_data, 32'h0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_aerr", {31'b0, addr_err}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_tout", {31'b0, timeout_err}, 32'd0);
        reset = 1'b0;
        tick();

        // Byte and halfword extraction, sign vs zero extension
        do_load("lb",   OP_LB,  32'h0000_1001, 32'h0, 32'h1280_3456, 0, 32'hFFFF_FF80, 1'b0);
        do_load("lbu",  OP_LBU, 32'h0000_1001, 32'h0, 32'h1280_3456, 0, 32'h0000_0080, 1'b0);
        do_load("lb3",  OP_LB,  32'h0000_1003, 32'h0, 32'h1280_347F, 0, 32'h0000_007F, 1'b0);
        do_load("lhu",  OP_LHU, 32'h0000_2002, 32'h0, 32'hAAAA_8001, 0, 32'h0000_8001, 1'b0);
        do_load("lh0",  OP_LH,  32'h0000_2000, 32'h0, 32'h8001_1234, 0, 32'hFFFF_8001, 1'b0);
        do_load("lw",   OP_LW,  32'h0000_3004, 32'h0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0);

        // Unaligned word merges with Rt
        do_load("lwl1", OP_LWL, 32'h0000_4001, 32'hAABB_CCDD, 32'h1122_3344, 0, 32'h2233_44DD, 1'b0);
        do_load("lwr1", OP_LWR, 32'h0000_4001, 32'hAABB_CCDD, 32'h1122_3344, 0, 32'hAABB_1122, 1'b0);
        do_load("lwl0", OP_LWL, 32'h0000_4000, 32'hAABB_CCDD, 32'h1122_3344, 0, 32'h1122_3344, 1'b0);
        do_load("lwr3", OP_LWR, 32'h0000_4003, 32'hAABB_CCDD, 32'h1122_3344, 0, 32'h1122_3344, 1'b0);
        do_load("lwl3", OP_LWL, 32'h0000_4003, 32'hAABB_CCDD, 32'h1122_3344, 0, 32'h44BB_CCDD, 1'b0);
        do_load("lwr0", OP_LWR, 32'h0000_4000, 32'hAABB_CCDD, 32'h1122_3344, 0, 32'hAABB_CC11, 1'b0);

        // Misaligned halfword: error pulse, no read, result held
        issue(OP_LH, 32'h0000_5001, 32'h0);
        check("lh_mis_aerr", {31'b0, addr_err}, 32'd1);
        check("lh_mis_req",  {31'b0, mem_rd_req}, 32'd0);
        check("lh_mis_busy", {31'b0, busy}, 32'd1);
        check("lh_mis_hold", load_data, 32'hAABB_CC11);
        tick();
        check("lh_mis_pulse", {31'b0, addr_err}, 32'd0);
        check("lh_mis_idle",  {31'b0, busy}, 32'd0);
        check("lh_mis_done",  {31'b0, done}, 32'd0);

        // Misaligned word
        issue(OP_LW, 32'h0000_5002, 32'h0);
        check("lw_mis_aerr", {31'b0, addr_err}, 32'd1);
        check("lw_mis_req",  {31'b0, mem_rd_req}, 32'd0);
        tick();

        // Non-load opcode is ignored
        issue(OP_SW, 32'h0000_6000, 32'h0);
        check("sw_busy", {31'b0, busy}, 32'd0);
        check("sw_req",  {31'b0, mem_rd_req}, 32'd0);

        // Delayed ready with start pulses arriving while busy
        do_load("slow", OP_LHU, 32'h0000_7002, 32'h0, 32'h1234_FEDC, 5, 32'h0000_FEDC, 1'b1);

        // Reset in the middle of a read
        issue(OP_LW, 32'h0000_8000, 32'h0);
        check("mid_req", {31'b0, mem_rd_req}, 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_req",  {31'b0, mem_rd_req}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_addr", mem_addr, 32'h0);
        check("mid_rst_data", load_data, 32'h0);
        tick();
        reset     = 1'b0;
        mem_rdy   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_rdy = 1'b0;
        check("mid_late_done", {31'b0, done}, 32'd0);
        check("mid_late_busy", {31'b0, busy}, 32'd0);
        check("mid_late_data", load_data, 32'h0);

`ifdef LOAD_ALIGN_TIMEOUT_EN
        // Ready never arrives: abort after 16 REQ cycles
        issue(OP_LW, 32'h0000_9000, 32'h0);
        for (int i = 1; i < 16; i++) tick();
        check("to_wait_busy", {31'b0, busy}, 32'd1);
        check("to_wait_tout", {31'b0, timeout_err}, 32'd0);
        tick();
        check("to_tout",  {31'b0, timeout_err}, 32'd1);
        check("to_busy",  {31'b0, busy}, 32'd0);
        check("to_done",  {31'b0, done}, 32'd0);
        check("to_data",  load_data, 32'h0);
        tick();
        check("to_pulse", {31'b0, timeout_err}, 32'd0);
        // Ready on the 16th REQ cycle wins
        do_load("to_edge", OP_LW, 32'h0000_9000, 32'h0, 32'h0BAD_CAFE, 15, 32'h0BAD_CAFE, 1'b0);
`else
        // Without the timeout the read waits as long as needed
        do_load("nowait", OP_LW, 32'h0000_9000, 32'h0, 32'h0BAD_CAFE, 20, 32'h0BAD_CAFE, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
